mem_access_seq: RTL and testbench
=================================

// Module: mem_access_seq
// PURPOSE
//  Sequences RV32 loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) onto the byte-only data memory.
//  The memory supports only SB writes (funct3 000) and LBU reads (funct3 100).
//  Splits each access into 1/2/4 single-byte beats, assembles and extends load data,
//  and stalls the core via a valid/ready handshake. Sits between the MEM stage and data_mem.
// PARAMETERS
//  DATA_WIDTH  32  width of address, store data and load result
// PORTS
//  clk           in   1   system clock; all state changes on posedge
//  rst           in   1   synchronous, active-high reset
//  req_valid_i   in   1   core presents an access
//  req_ready_o   out  1   block can accept an access (IDLE only)
//  req_we_i      in   1   1 = store, 0 = load
//  req_funct3_i  in   3   RV32 load/store funct3
//  req_addr_i    in   32  byte address (misaligned allowed)
//  req_wdata_i   in   32  store data; bytes taken LSB first
//  done_o        out  1   one-cycle pulse: access complete
//  err_o         out  1   valid with done_o; 1 = illegal funct3, no memory beats issued
//  rdata_o       out  32  load result; held from done_o until next load completes
//  mem_addr_o    out  32  byte address to data memory
//  mem_wdata_o   out  32  {24'b0, current store byte}
//  mem_we_o      out  1   memory write enable
//  mem_funct3_o  out  3   000 on store beats, 100 on load beats and when idle
//  mem_rdata_i   in   32  memory read data; [7:0] valid combinationally (async read)
// BEHAVIOUR
//  Reset
//   - state=IDLE, req_ready_o=1, done_o=0, err_o=0, rdata_o=0, mem_we_o=0.
//   - mem_addr_o=0, mem_funct3_o=100.
//  States
//   - IDLE: accept on posedge when req_valid_i & req_ready_o; latch we/funct3/addr/wdata; clear beat count.
//       -> ACCESS if funct3[1:0] in {00,01,10} and funct3 is not 110 (also rejected for stores if funct3[2]=1).
//       -> ERR otherwise.
//   - ACCESS: beat k (k=0..N-1; N=1/2/4 for funct3[1:0]=00/01/10).
//       mem_addr_o = addr+k, 32-bit modulo 2^32. Store: mem_we_o=1, mem_wdata_o[7:0]=wdata[8k+7:8k].
//       Load: byte k captured from mem_rdata_i[7:0] at end of beat into result[8k+7:8k].
//       After beat N-1 -> IDLE with done_o=1.
//   - ERR: one cycle, no memory activity; -> IDLE with done_o=1, err_o=1.
//  Latency and handshake
//   - done_o is high N+1 cycles after the accepting edge; ERR completes after 2 cycles.
//   - req_ready_o=1 in IDLE, including the done_o cycle, so back-to-back accesses lose no cycle.
//  Load result
//   - funct3[2]=0: sign-extend from bit 8N-1. funct3[2]=1: zero-extend.
//   - rdata_o updates only on a load's done edge. Stores and errors leave rdata_o unchanged.
//  Misalignment and wrap
//   - No alignment trap. Bytes are always little-endian at consecutive addresses.
//   - The memory uses only the low address bits, so addr+k wrapping past its size aliases to low addresses.
//  Reset mid-operation
//   - Returns to IDLE on the next edge; mem_we_o=0 from that cycle.
//   - Bytes already written stay written. No done_o for the aborted access.
//  Other rules
//   - A request with req_valid_i high while not ready is ignored; the core must hold it.
//   - done_o never asserts without a preceding accept.
//   - mem_we_o is never high outside ACCESS with a store.
// TESTING
//  - Preload 0x10000..03 = 11 22 33 84; LW 0x10000 -> done_o 5 cycles after accept, rdata_o=0x84332211, err_o=0.
//  - LH 0x10002 -> rdata_o=0xFFFF8433; LHU 0x10002 -> 0x00008433; LB 0x10003 -> 0xFFFFFF84, done after 2 cycles.
//  - SW 0x10010 data 0xDEADBEEF -> mem_we_o high 4 consecutive cycles.
//      Bytes EF,BE,AD,DE at 0x10010..13; then LW 0x10010 -> 0xDEADBEEF; rdata_o unchanged by the SW.
//  - SH 0x1FFFF data 0x0000A55A -> 5A to 0x1FFFF, A5 to mem_addr_o 0x00020000 (aliases to byte 0).
//  - Load funct3=011 -> err_o=1 with done_o 2 cycles after accept; store funct3=100 -> err_o=1.
//      mem_we_o never asserted and rdata_o unchanged in both cases.
//  - SW 0x10020 data 0x44332211, assert rst after 2 beats -> next cycle mem_we_o=0, req_ready_o=1, no done_o.
//      Only 0x10020=11 and 0x10021=22 written.

Source files
------------

// File: rtl/mem_access_seq_if.sv
// Core-side request/response and byte-memory signals of the load/store sequencer.
// The master modport is the environment (core + data memory); slave is the sequencer.
interface mem_access_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [2:0]            req_funct3_i;
    logic [DATA_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic                  done_o;
    logic                  err_o;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic [DATA_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_we_o;
    logic [2:0]            mem_funct3_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport master (
        output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_rdata_i,
        input  req_ready_o, done_o, err_o, rdata_o,
        input  mem_addr_o, mem_wdata_o, mem_we_o, mem_funct3_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_rdata_i,
        output req_ready_o, done_o, err_o, rdata_o,
        output mem_addr_o, mem_wdata_o, mem_we_o, mem_funct3_o
    );
endinterface

// File: rtl/mem_access_seq.sv
// Splits RV32 loads/stores into single-byte beats (SB writes / LBU reads) on a byte-only
// data memory, assembles and extends load data, and handshakes with the core.
module mem_access_seq #(
    parameter int DATA_WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    mem_access_seq_if.slave bus
);
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_LBU = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ERR} state_e;

    state_e                state_q, state_d;
    logic [1:0]            beat_q, beat_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]            mem_wbyte_q, mem_wbyte_d;
    logic                  mem_we_q, mem_we_d;
    logic [2:0]            mem_funct3_q, mem_funct3_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  legal;
    logic [1:0]            last_beat;
    logic                  sign_bit;
    logic [DATA_WIDTH-1:0] assembled;
    logic [DATA_WIDTH-1:0] extended;
    logic                  unused_rdata_hi;

    assign unused_rdata_hi = |bus.mem_rdata_i[DATA_WIDTH-1:8];

    // Stores have no unsigned variants, so funct3[2] set on a store is illegal too.
    assign legal = (bus.req_funct3_i[1:0] != 2'b11) && (bus.req_funct3_i != 3'b110)
                && !(bus.req_we_i && bus.req_funct3_i[2]);

    // Index of the final beat: 0, 1 or 3 for byte, half and word.
    assign last_beat = {funct3_q[1], funct3_q[1] | funct3_q[0]};

    always_comb begin
        assembled = result_q;
        assembled[{beat_q, 3'b000} +: 8] = bus.mem_rdata_i[7:0];
    end

    always_comb begin
        sign_bit = 1'b0;
        extended = assembled;
        case (funct3_q[1:0])
            2'b00: begin
                sign_bit = ~funct3_q[2] & assembled[7];
                extended = {{(DATA_WIDTH-8){sign_bit}}, assembled[7:0]};
            end
            2'b01: begin
                sign_bit = ~funct3_q[2] & assembled[15];
                extended = {{(DATA_WIDTH-16){sign_bit}}, assembled[15:0]};
            end
            default: extended = assembled;
        endcase
    end

    always_comb begin
        // NOTE: every _d starts from a default so no path through the case can infer a latch.
        state_d      = state_q;
        beat_d       = beat_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        result_d     = result_q;
        rdata_d      = rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wbyte_d  = mem_wbyte_q;
        mem_we_d     = mem_we_q;
        mem_funct3_d = mem_funct3_q;
        ready_d      = ready_q;
        done_d       = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid_i && ready_q) begin
                    we_d     = bus.req_we_i;
                    funct3_d = bus.req_funct3_i;
                    beat_d   = 2'd0;
                    result_d = '0;
                    ready_d  = 1'b0;
                    if (legal) begin
                        state_d      = S_ACCESS;
                        mem_addr_d   = bus.req_addr_i;
                        mem_we_d     = bus.req_we_i;
                        mem_funct3_d = bus.req_we_i ? F3_SB : F3_LBU;
                        mem_wbyte_d  = bus.req_we_i ? bus.req_wdata_i[7:0] : 8'h00;
                        wdata_d      = bus.req_wdata_i >> 8;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_ACCESS: begin
                result_d = assembled;
                if (beat_q == last_beat) begin
                    state_d      = S_IDLE;
                    ready_d      = 1'b1;
                    done_d       = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_funct3_d = F3_LBU;
                    mem_wbyte_d  = 8'h00;
                    if (!we_q) rdata_d = extended;
                end else begin
                    beat_d      = beat_q + 2'd1;
                    mem_addr_d  = mem_addr_q + DATA_WIDTH'(1);
                    mem_wbyte_d = wdata_q[7:0];
                    wdata_d     = wdata_q >> 8;
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                done_d  = 1'b1;
                err_d   = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so all flops sample together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            beat_q       <= 2'd0;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            wdata_q      <= '0;
            result_q     <= '0;
            rdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_wbyte_q  <= 8'h00;
            mem_we_q     <= 1'b0;
            mem_funct3_q <= F3_LBU;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            result_q     <= result_d;
            rdata_q      <= rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wbyte_q  <= mem_wbyte_d;
            mem_we_q     <= mem_we_d;
            mem_funct3_q <= mem_funct3_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.req_ready_o  = ready_q;
    assign bus.done_o       = done_q;
    assign bus.err_o        = err_q;
    assign bus.rdata_o      = rdata_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_wdata_o  = {{(DATA_WIDTH-8){1'b0}}, mem_wbyte_q};
    assign bus.mem_we_o     = mem_we_q;
    assign bus.mem_funct3_o = mem_funct3_q;
endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: a 128 KiB byte memory model with async read,
// hand-computed expected results for loads, stores, wrap, errors and mid-access reset.
module tb_mem_access_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_seq_if #(.DATA_WIDTH(32)) bus ();

    mem_access_seq #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Byte memory: only the low 17 address bits are decoded, so 0x20000 aliases to 0.
    logic [7:0]  mem_arr [0:131071];
    logic        pre_we = 1'b0;
    logic [16:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;
    int          we_total = 0;
    int          bad_f3 = 0;
    logic [31:0] last_we_addr = '0;

    assign bus.mem_rdata_i = {24'h0, mem_arr[bus.mem_addr_o[16:0]]};

    always @(posedge clk) begin
        if (pre_we) begin
            mem_arr[pre_addr] <= pre_data;
        end else if (bus.mem_we_o) begin
            mem_arr[bus.mem_addr_o[16:0]] <= bus.mem_wdata_o[7:0];
            we_total     <= we_total + 1;
            last_we_addr <= bus.mem_addr_o;
            if (bus.mem_funct3_o != 3'b000) bad_f3 <= bad_f3 + 1;
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic preload(input logic [16:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Issues one access and returns how many edges after the accepting edge done_o rose
    // (-1 on timeout) plus the number of memory write cycles seen meanwhile.
    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, output int lat, output int we_cnt);
        int start;
        int w;
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_we_i = we; bus.req_funct3_i = f3;
        bus.req_addr_i = addr; bus.req_wdata_i = wdata;
        w = 0;
        while (!bus.req_ready_o && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        start = we_total;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (bus.done_o) begin
                lat = k;
                break;
            end
        end
        we_cnt = we_total - start;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.req_ready_o); end
        n_cmp++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
        n_cmp++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err_o); end
        n_cmp++; if (bus.rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.rdata_o); end
        n_cmp++; if (bus.mem_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we_o); end
        n_cmp++; if (bus.mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr_o); end
        n_cmp++; if (bus.mem_funct3_o !== 3'b100) begin n_fail++; $display("FAIL reset_mem_funct3: got %b want 100", bus.mem_funct3_o); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_loads;
        int lat, wc;
        preload(17'h10000, 8'h11); preload(17'h10001, 8'h22);
        preload(17'h10002, 8'h33); preload(17'h10003, 8'h84);
        // LW: done in the cycle after the 4th edge following accept.
        do_access(1'b0, 3'b010, 32'h0001_0000, 32'h0, lat, wc);
        n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL lw_latency: got %0d want 4", lat); end
        n_cmp++; if (bus.rdata_o !== 32'h8433_2211) begin n_fail++; $display("FAIL lw_rdata: got %h want 84332211", bus.rdata_o); end
        n_cmp++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL lw_err: got %b want 0", bus.err_o); end
        n_cmp++; if (wc !== 0) begin n_fail++; $display("FAIL lw_no_write: got %0d want 0", wc); end
        @(posedge clk); #1;
        n_cmp++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: got %b want 0", bus.done_o); end
        do_access(1'b0, 3'b001, 32'h0001_0002, 32'h0, lat, wc);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL lh_latency: got %0d want 2", lat); end
        n_cmp++; if (bus.rdata_o !== 32'hFFFF_8433) begin n_fail++; $display("FAIL lh_rdata: got %h want ffff8433", bus.rdata_o); end
        do_access(1'b0, 3'b101, 32'h0001_0002, 32'h0, lat, wc);
        n_cmp++; if (bus.rdata_o !== 32'h0000_8433) begin n_fail++; $display("FAIL lhu_rdata: got %h want 00008433", bus.rdata_o); end
        do_access(1'b0, 3'b100, 32'h0001_0003, 32'h0, lat, wc);
        n_cmp++; if (bus.rdata_o !== 32'h0000_0084) begin n_fail++; $display("FAIL lbu_rdata: got %h want 00000084", bus.rdata_o); end
        do_access(1'b0, 3'b000, 32'h0001_0003, 32'h0, lat, wc);
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL lb_latency: got %0d want 1", lat); end
        n_cmp++; if (bus.rdata_o !== 32'hFFFF_FF84) begin n_fail++; $display("FAIL lb_rdata: got %h want ffffff84", bus.rdata_o); end
    endtask

    task automatic test_store;
        int lat, wc;
        do_access(1'b1, 3'b010, 32'h0001_0010, 32'hDEAD_BEEF, lat, wc);
        n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL sw_latency: got %0d want 4", lat); end
        n_cmp++; if (wc !== 4) begin n_fail++; $display("FAIL sw_write_cycles: got %0d want 4", wc); end
        n_cmp++; if (bus.rdata_o !== 32'hFFFF_FF84) begin n_fail++; $display("FAIL sw_rdata_kept: got %h want ffffff84", bus.rdata_o); end
        n_cmp++; if ({mem_arr[17'h10013], mem_arr[17'h10012], mem_arr[17'h10011], mem_arr[17'h10010]} !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL sw_bytes: got %h%h%h%h want deadbeef", mem_arr[17'h10013], mem_arr[17'h10012], mem_arr[17'h10011], mem_arr[17'h10010]);
        end
        do_access(1'b0, 3'b010, 32'h0001_0010, 32'h0, lat, wc);
        n_cmp++; if (bus.rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_after_sw: got %h want deadbeef", bus.rdata_o); end
    endtask

    task automatic test_wrap;
        int lat, wc;
        do_access(1'b1, 3'b001, 32'h0001_FFFF, 32'h0000_A55A, lat, wc);
        n_cmp++; if (wc !== 2) begin n_fail++; $display("FAIL sh_write_cycles: got %0d want 2", wc); end
        n_cmp++; if (mem_arr[17'h1FFFF] !== 8'h5A) begin n_fail++; $display("FAIL sh_byte0: got %h want 5a", mem_arr[17'h1FFFF]); end
        n_cmp++; if (mem_arr[17'h00000] !== 8'hA5) begin n_fail++; $display("FAIL sh_byte1_alias: got %h want a5", mem_arr[17'h00000]); end
        n_cmp++; if (last_we_addr !== 32'h0002_0000) begin n_fail++; $display("FAIL sh_beat1_addr: got %h want 00020000", last_we_addr); end
        n_cmp++; if (bus.rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sh_rdata_kept: got %h want deadbeef", bus.rdata_o); end
    endtask

    task automatic test_errors;
        int lat, wc;
        do_access(1'b0, 3'b011, 32'h0001_0000, 32'h0, lat, wc);
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL ld011_latency: got %0d want 1", lat); end
        n_cmp++; if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL ld011_err: got %b want 1", bus.err_o); end
        n_cmp++; if (wc !== 0) begin n_fail++; $display("FAIL ld011_no_write: got %0d want 0", wc); end
        n_cmp++; if (bus.rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ld011_rdata_kept: got %h want deadbeef", bus.rdata_o); end
        do_access(1'b1, 3'b100, 32'h0001_0000, 32'h1234_5678, lat, wc);
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL st100_latency: got %0d want 1", lat); end
        n_cmp++; if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL st100_err: got %b want 1", bus.err_o); end
        n_cmp++; if (wc !== 0) begin n_fail++; $display("FAIL st100_no_write: got %0d want 0", wc); end
        n_cmp++; if (mem_arr[17'h10000] !== 8'h11) begin n_fail++; $display("FAIL st100_mem_kept: got %h want 11", mem_arr[17'h10000]); end
        n_cmp++; if (bus.rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL st100_rdata_kept: got %h want deadbeef", bus.rdata_o); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_funct3_i = 3'b100;
        bus.req_addr_i = 32'h0001_0000; bus.req_wdata_i = 32'h0;
        @(posedge clk); #1;
        // Next request is presented at once and must wait while the first is busy.
        bus.req_addr_i = 32'h0001_0001;
        n_cmp++; if (bus.req_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_ready: got %b want 0", bus.req_ready_o); end
        @(posedge clk); #1;
        n_cmp++; if (bus.done_o !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b want 1", bus.done_o); end
        n_cmp++; if (bus.rdata_o !== 32'h0000_0011) begin n_fail++; $display("FAIL b2b_first_rdata: got %h want 00000011", bus.rdata_o); end
        n_cmp++; if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_on_done: got %b want 1", bus.req_ready_o); end
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        n_cmp++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_done: got %b want 0", bus.done_o); end
        @(posedge clk); #1;
        n_cmp++; if (bus.done_o !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done: got %b want 1", bus.done_o); end
        n_cmp++; if (bus.rdata_o !== 32'h0000_0022) begin n_fail++; $display("FAIL b2b_second_rdata: got %h want 00000022", bus.rdata_o); end
    endtask

    task automatic test_reset_mid;
        int start;
        int seen_done;
        preload(17'h10022, 8'hEE); preload(17'h10023, 8'hEE);
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_funct3_i = 3'b010;
        bus.req_addr_i = 32'h0001_0020; bus.req_wdata_i = 32'h4433_2211;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        start = we_total;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus.mem_we_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_mem_we: got %b want 0", bus.mem_we_o); end
        n_cmp++; if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", bus.req_ready_o); end
        n_cmp++; if (bus.rdata_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_rdata: got %h want 0", bus.rdata_o); end
        rst = 1'b0;
        seen_done = bus.done_o ? 1 : 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.done_o) seen_done++;
        end
        n_cmp++; if (seen_done !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses want 0", seen_done); end
        n_cmp++; if (we_total - start !== 2) begin n_fail++; $display("FAIL rstmid_write_cycles: got %0d want 2", we_total - start); end
        n_cmp++; if ({mem_arr[17'h10023], mem_arr[17'h10022], mem_arr[17'h10021], mem_arr[17'h10020]} !== 32'hEEEE_2211) begin
            n_fail++;
            $display("FAIL rstmid_bytes: got %h%h%h%h want eeee2211", mem_arr[17'h10023], mem_arr[17'h10022], mem_arr[17'h10021], mem_arr[17'h10020]);
        end
    endtask

    initial begin
        bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_funct3_i = 3'b000;
        bus.req_addr_i = '0; bus.req_wdata_i = '0;
        test_reset();
        test_loads();
        test_store();
        test_wrap();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        n_cmp++; if (bad_f3 !== 0) begin n_fail++; $display("FAIL write_funct3: got %0d bad writes want 0", bad_f3); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
